// File: rtl/his_pkg.sv
// Shared types and helpers for the histogram statistics engine.
package his_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StAcc,
        StDrain,
        StScan,
        StOut,
        StClear
    } his_state_e;

    function automatic int unsigned bins_of(input int unsigned data_w);
        return 1 << data_w;
    endfunction

    // Width of an unsigned sum with room for the carry that flags saturation.
    function automatic int unsigned sat_sum_w(input int unsigned w);
        return w + 1;
    endfunction

endpackage

// File: rtl/his_bin_ram.sv
// Simple dual-port bin memory: synchronous write, registered read (old data on collision).
module his_bin_ram #(
    parameter int unsigned Depth = 256,
    parameter int unsigned AddrW = 8,
    parameter int unsigned DataW = 20
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/his_stat_clip.sv
// Per-frame grey-level histogram with optional global clip/redistribute, streamed out as a CDF.
import his_pkg::*;

module his_stat_clip #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned COUNT_W   = 20,
    parameter int unsigned IMG_TOTAL = 480000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               per_img_vsync,
    input  logic               per_img_href,
    input  logic [DATA_W-1:0]  per_img_gray,
    input  logic               clip_en,
    input  logic [COUNT_W-1:0] clip_limit,
    output logic [DATA_W-1:0]  pixel_level,
    output logic [COUNT_W-1:0] pixel_level_acc_num,
    output logic               pixel_level_valid,
    output logic               hist_done,
    output logic               busy,
    output logic               frame_dropped,
    output logic [COUNT_W-1:0] frame_pix_cnt
);

    localparam int unsigned Bins = bins_of(DATA_W);
    localparam int unsigned SumW = sat_sum_w(COUNT_W);

    if (COUNT_W < $clog2(IMG_TOTAL + 1)) begin : g_size_check
        $error("COUNT_W too narrow to hold IMG_TOTAL");
    end

    function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                   input logic [COUNT_W-1:0] b);
        logic [SumW-1:0] s;
        s = SumW'(a) + SumW'(b);
        return s[COUNT_W] ? '1 : s[COUNT_W-1:0];
    endfunction

    his_state_e         state_q, state_d;
    logic [DATA_W-1:0]  cnt_q, cnt_d;
    logic               vs_q, vs_rise, vs_fall;

    logic               p1_vld_q, w1_vld_q, w2_vld_q;
    logic [DATA_W-1:0]  p1_bin_q, w1_bin_q, w2_bin_q;
    logic [COUNT_W-1:0] w1_val_q, w2_val_q;

    logic               clip_en_q;
    logic [COUNT_W-1:0] limit_q, excess_q, cdf_q, pix_cnt_q;
    logic               rd_vld_q, rd_out_q;
    logic [DATA_W-1:0]  rd_idx_q, level_q;
    logic [COUNT_W-1:0] acc_num_q;
    logic               valid_q, done_q, busy_q, dropped_q;

    logic               pix_fire, ram_we, over;
    logic [DATA_W-1:0]  ram_waddr, ram_raddr;
    logic [COUNT_W-1:0] ram_wdata, ram_rdata, fwd_val, inc_val;
    logic [COUNT_W-1:0] excess_inc, clipped, add, cdf_next;

    assign vs_rise  = per_img_vsync & ~vs_q;
    assign vs_fall  = ~per_img_vsync & vs_q;
    assign pix_fire = (state_q == StAcc) && per_img_href;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit, StClear: begin
                cnt_d = cnt_q + DATA_W'(1);
                if (cnt_q == '1) state_d = StIdle;
            end
            StIdle: begin
                cnt_d = '0;
                if (vs_rise) state_d = StAcc;
            end
            StAcc: begin
                cnt_d = '0;
                if (vs_fall) state_d = StDrain;
            end
            StDrain: begin
                cnt_d = cnt_q + DATA_W'(1);
                if (cnt_q == DATA_W'(1)) begin
                    state_d = StScan;
                    cnt_d   = '0;
                end
            end
            StScan, StOut: begin
                cnt_d = cnt_q + DATA_W'(1);
                if (cnt_q == '1) state_d = (state_q == StScan) ? StOut : StClear;
            end
            default: state_d = StInit;
        endcase
    end

    // Forward the two most recent writes so back-to-back hits on one bin never lose a count.
    always_comb begin
        fwd_val = ram_rdata;
        if (w1_vld_q && (w1_bin_q == p1_bin_q)) begin
            fwd_val = w1_val_q;
        end else if (w2_vld_q && (w2_bin_q == p1_bin_q)) begin
            fwd_val = w2_val_q;
        end
        inc_val = sat_add(fwd_val, COUNT_W'(1));

        ram_we    = 1'b0;
        ram_waddr = cnt_q;
        ram_wdata = '0;
        if ((state_q == StInit) || (state_q == StClear)) begin
            ram_we = 1'b1;
        end else if (p1_vld_q) begin
            ram_we    = 1'b1;
            ram_waddr = p1_bin_q;
            ram_wdata = inc_val;
        end
        ram_raddr = (state_q == StAcc) ? per_img_gray : cnt_q;

        over       = clip_en_q && (ram_rdata > limit_q);
        excess_inc = over ? (ram_rdata - limit_q) : '0;
        clipped    = over ? limit_q : ram_rdata;
        add        = excess_q >> DATA_W;
        cdf_next   = sat_add(sat_add(cdf_q, clipped), add);
    end

    his_bin_ram #(
        .Depth (Bins),
        .AddrW (DATA_W),
        .DataW (COUNT_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            vs_q      <= 1'b0;
            p1_vld_q  <= 1'b0;
            p1_bin_q  <= '0;
            w1_vld_q  <= 1'b0;
            w1_bin_q  <= '0;
            w1_val_q  <= '0;
            w2_vld_q  <= 1'b0;
            w2_bin_q  <= '0;
            w2_val_q  <= '0;
            clip_en_q <= 1'b0;
            limit_q   <= '0;
            excess_q  <= '0;
            cdf_q     <= '0;
            pix_cnt_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_out_q  <= 1'b0;
            rd_idx_q  <= '0;
            level_q   <= '0;
            acc_num_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vs_q     <= per_img_vsync;
            p1_vld_q <= pix_fire;
            p1_bin_q <= per_img_gray;
            w1_vld_q <= p1_vld_q;
            w1_bin_q <= p1_bin_q;
            w1_val_q <= inc_val;
            w2_vld_q <= w1_vld_q;
            w2_bin_q <= w1_bin_q;
            w2_val_q <= w1_val_q;

            if ((state_q == StIdle) && vs_rise) begin
                pix_cnt_q <= '0;
            end else if (pix_fire) begin
                pix_cnt_q <= sat_add(pix_cnt_q, COUNT_W'(1));
            end

            if ((state_q == StAcc) && vs_fall) begin
                clip_en_q <= clip_en;
                limit_q   <= clip_limit;
                excess_q  <= '0;
                cdf_q     <= '0;
            end else if (rd_vld_q && !rd_out_q) begin
                excess_q <= sat_add(excess_q, excess_inc);
            end else if (rd_vld_q && rd_out_q) begin
                cdf_q <= cdf_next;
            end

            rd_vld_q <= (state_q == StScan) || (state_q == StOut);
            rd_out_q <= (state_q == StOut);
            rd_idx_q <= cnt_q;

            valid_q <= rd_vld_q && rd_out_q;
            if (rd_vld_q && rd_out_q) begin
                level_q   <= rd_idx_q;
                acc_num_q <= cdf_next;
            end
            done_q    <= valid_q && (level_q == '1);
            busy_q    <= (state_q != StIdle) && (state_q != StAcc);
            dropped_q <= vs_rise && (state_q != StIdle);
        end
    end

    assign pixel_level         = level_q;
    assign pixel_level_acc_num = acc_num_q;
    assign pixel_level_valid   = valid_q;
    assign hist_done           = done_q;
    assign busy                = busy_q;
    assign frame_dropped       = dropped_q;
    assign frame_pix_cnt       = pix_cnt_q;

endmodule
